// File: rtl/lx9_board_main.sv
// rtl/lx9_board_main.sv - LX9 board command channel: one-shot POR sequencer plus TX->RX byte loopback FIFOs.
// Optional macro LX9_LED_GATE_EN: mover only transfers while the registered tb_led (led_q) is high.
module lx9_board_main #(
    parameter int DEPTH          = 16,
    parameter int POR_CYCLES     = 8,
    parameter int RST_MIN_CYCLES = 4
) (
    input  logic       tb_clk,
    output logic       rst_out,
    input  logic       rst_out_ack,
    input  logic       tb_led,
    input  logic [7:0] cmdfifo_txdata,
    input  logic       cmdfifo_wr,
    output logic       cmdfifo_txf,
    input  logic       cmdfifo_rd,
    output logic [7:0] cmdfifo_rxdata,
    output logic       cmdfifo_rxe
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [15:0] POR_LAST = 16'(POR_CYCLES - 1);
    localparam logic [15:0] MIN_LAST = 16'(RST_MIN_CYCLES - 1);

`ifdef LX9_LED_GATE_EN
    localparam logic LED_GATE = 1'b1;
`else
    localparam logic LED_GATE = 1'b0;
`endif

    typedef enum logic [1:0] {
        POR_IDLE,
        POR_ASSERT,
        POR_DONE
    } por_state_t;

    // The sequencer is the only logic outside rst_out's domain; it starts from its configuration value.
    por_state_t  por_state = POR_IDLE;
    logic [15:0] por_cnt   = 16'd0;
    logic        rst_q     = 1'b0;

    assign rst_out = rst_q;

    always_ff @(posedge tb_clk) begin
        case (por_state)
            POR_IDLE: begin
                if (por_cnt == POR_LAST) begin
                    rst_q     <= 1'b1;
                    por_cnt   <= 16'd0;
                    por_state <= POR_ASSERT;
                end else begin
                    por_cnt <= por_cnt + 16'd1;
                end
            end
            POR_ASSERT: begin
                if (por_cnt == MIN_LAST && rst_out_ack) begin
                    rst_q     <= 1'b0;
                    por_state <= POR_DONE;
                end else if (por_cnt != MIN_LAST) begin
                    por_cnt <= por_cnt + 16'd1;
                end
            end
            default: begin
                rst_q     <= 1'b0;
                por_state <= POR_DONE;
            end
        endcase
    end

    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic [CW-1:0] tx_cnt_nxt, rx_cnt_nxt;
    logic          led_q;
    logic          move_gate;
    logic          do_wr, do_mv, do_rd;

    assign move_gate = led_q | ~LED_GATE;

    // Every decision uses start-of-cycle counts, so write, move and read can share an edge safely.
    assign do_wr = cmdfifo_wr && (tx_cnt != FULL_CNT);
    assign do_mv = (tx_cnt != '0) && (rx_cnt != FULL_CNT) && move_gate;
    assign do_rd = cmdfifo_rd && (rx_cnt != '0);

    assign tx_cnt_nxt = tx_cnt + CW'(do_wr) - CW'(do_mv);
    assign rx_cnt_nxt = rx_cnt + CW'(do_mv) - CW'(do_rd);

    always_ff @(posedge tb_clk) begin
        if (!rst_out) begin
            if (do_wr) begin
                tx_mem[tx_wr_ptr] <= cmdfifo_txdata;
            end
            if (do_mv) begin
                rx_mem[rx_wr_ptr] <= tx_mem[tx_rd_ptr];
            end
        end
    end

    always_ff @(posedge tb_clk or posedge rst_out) begin
        if (rst_out) begin
            tx_wr_ptr      <= '0;
            tx_rd_ptr      <= '0;
            rx_wr_ptr      <= '0;
            rx_rd_ptr      <= '0;
            tx_cnt         <= '0;
            rx_cnt         <= '0;
            led_q          <= 1'b0;
            cmdfifo_txf    <= 1'b0;
            cmdfifo_rxe    <= 1'b1;
            cmdfifo_rxdata <= 8'h00;
        end else begin
            led_q       <= tb_led;
            tx_cnt      <= tx_cnt_nxt;
            rx_cnt      <= rx_cnt_nxt;
            cmdfifo_txf <= (tx_cnt_nxt == FULL_CNT);
            cmdfifo_rxe <= (rx_cnt_nxt == '0);
            if (do_wr) begin
                tx_wr_ptr <= tx_wr_ptr + 1'b1;
            end
            if (do_mv) begin
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
                rx_wr_ptr <= rx_wr_ptr + 1'b1;
            end
            if (do_rd) begin
                cmdfifo_rxdata <= rx_mem[rx_rd_ptr];
                rx_rd_ptr      <= rx_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lx9_board_main.sv
// tb/tb_lx9_board_main.sv - randomized scoreboard bench for lx9_board_main against a two-queue reference model.
module tb_lx9_board_main;

    localparam int DEPTH          = 16;
    localparam int POR_CYCLES     = 8;
    localparam int RST_MIN_CYCLES = 4;

    logic       tb_clk = 1'b0;
    logic       rst_out;
    logic       rst_out_ack;
    logic       tb_led;
    logic [7:0] cmdfifo_txdata;
    logic       cmdfifo_wr;
    logic       cmdfifo_txf;
    logic       cmdfifo_rd;
    logic [7:0] cmdfifo_rxdata;
    logic       cmdfifo_rxe;

    always #10 tb_clk = ~tb_clk;

    lx9_board_main #(
        .DEPTH(DEPTH),
        .POR_CYCLES(POR_CYCLES),
        .RST_MIN_CYCLES(RST_MIN_CYCLES)
    ) dut (
        .tb_clk(tb_clk),
        .rst_out(rst_out),
        .rst_out_ack(rst_out_ack),
        .tb_led(tb_led),
        .cmdfifo_txdata(cmdfifo_txdata),
        .cmdfifo_wr(cmdfifo_wr),
        .cmdfifo_txf(cmdfifo_txf),
        .cmdfifo_rd(cmdfifo_rd),
        .cmdfifo_rxdata(cmdfifo_rxdata),
        .cmdfifo_rxe(cmdfifo_rxe)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: end-to-end byte stream through two bounded queues, one hop per cycle.
    byte unsigned tx_q[$];
    byte unsigned rx_q[$];
    byte unsigned exp_q[$];
    logic       rd_done  = 1'b0;
    logic       por_seen = 1'b0;
    logic [7:0] last_rx  = 8'h00;
    int         reads_total = 0;
`ifdef LX9_LED_GATE_EN
    logic       led_m = 1'b0;
`endif

    always @(posedge tb_clk) begin
        int  ts, rs;
        bit  g, r_ok, m_ok, w_ok;
        rd_done = 1'b0;
        if (!rst_out) begin
            ts = tx_q.size();
            rs = rx_q.size();
`ifdef LX9_LED_GATE_EN
            g     = led_m;
            led_m = tb_led;
`else
            g = 1'b1;
`endif
            r_ok = cmdfifo_rd && rs > 0;
            m_ok = ts > 0 && rs < DEPTH && g;
            w_ok = cmdfifo_wr && ts < DEPTH;
            if (r_ok) begin
                exp_q.push_back(rx_q.pop_front());
                rd_done = 1'b1;
            end
            if (m_ok) rx_q.push_back(tx_q.pop_front());
            if (w_ok) tx_q.push_back(cmdfifo_txdata);
        end else begin
`ifdef LX9_LED_GATE_EN
            led_m = 1'b0;
`endif
        end
    end

    always @(negedge tb_clk) begin
        if (rst_out) begin
            por_seen = 1'b1;
            tx_q.delete();
            rx_q.delete();
            exp_q.delete();
            last_rx = 8'h00;
            chk("reset_rxe", 32'(cmdfifo_rxe), 32'd1);
            chk("reset_txf", 32'(cmdfifo_txf), 32'd0);
            chk("reset_rxdata", 32'(cmdfifo_rxdata), 32'h00);
        end else if (por_seen) begin
            chk("rxe", 32'(cmdfifo_rxe), 32'(rx_q.size() == 0));
            chk("txf", 32'(cmdfifo_txf), 32'(tx_q.size() == DEPTH));
            if (rd_done) begin
                reads_total++;
                if (exp_q.size() == 0) chk("scoreboard_underflow", 32'd1, 32'd0);
                else last_rx = exp_q.pop_front();
            end
            chk("rxdata", 32'(cmdfifo_rxdata), 32'(last_rx));
        end
    end

    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        @(negedge tb_clk);
        cmdfifo_wr     = w;
        cmdfifo_txdata = d;
        cmdfifo_rd     = r;
    endtask

    task automatic wait_rx(input string name);
        int n = 0;
        while (cmdfifo_rxe && n < 20) begin
            cyc(1'b0, 8'h00, 1'b0);
            n++;
        end
        chk(name, 32'(n < 20), 32'd1);
    endtask

    task automatic rd_byte(output logic [7:0] v);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        v = cmdfifo_rxdata;
    endtask

    task automatic drain();
        int n = 0;
        while ((tx_q.size() + rx_q.size()) > 0 && n < 300) begin
            cyc(1'b0, 8'h00, !cmdfifo_rxe);
            n++;
        end
        cyc(1'b0, 8'h00, 1'b0);
        chk("drain_bound", 32'(n < 300), 32'd1);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n, base;
        int         v567;
        logic [7:0] v, held;
        rst_out_ack    = 1'b0;
        tb_led         = 1'b1;
        cmdfifo_wr     = 1'b0;
        cmdfifo_rd     = 1'b0;
        cmdfifo_txdata = 8'h00;

        n = 0;
        while (!rst_out && n < 50) begin
            @(posedge tb_clk);
            #1;
            n++;
        end
        chk("por_rise_edges", 32'(n), 32'(POR_CYCLES));
        repeat (10) @(negedge tb_clk);
        chk("rst_held_no_ack", 32'(rst_out), 32'd1);
        rst_out_ack = 1'b1;
        n = 0;
        while (rst_out && n < 20) begin
            @(posedge tb_clk);
            #1;
            n++;
        end
        chk("rst_release_bound", 32'(n <= RST_MIN_CYCLES && !rst_out), 32'd1);
        @(negedge tb_clk);
        rst_out_ack = 1'b0;
        repeat (6) @(negedge tb_clk);
        chk("rst_stays_low", 32'(rst_out), 32'd0);

        cyc(1'b1, 8'h41, 1'b0);
        cyc(1'b1, 8'h42, 1'b0);
        cyc(1'b1, 8'h43, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wait_rx("abc_wait");
            rd_byte(v);
            chk("abc_order", 32'(v), 32'(8'h41 + i));
        end
        cyc(1'b0, 8'h00, 1'b0);
        chk("abc_empty", 32'(cmdfifo_rxe), 32'd1);

        v567 = 567;
        cyc(1'b1, v567[7:0], 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        wait_rx("trunc_wait");
        rd_byte(v);
        chk("trunc_567", 32'(v), 32'h37);

        for (int i = 0; i < 2 * DEPTH + 1; i++) cyc(1'b1, 8'($urandom), 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("backpressure_txf", 32'(cmdfifo_txf), 32'd1);
        base = reads_total;
        drain();
        chk("backpressure_count", 32'(reads_total - base), 32'(2 * DEPTH));

        held = cmdfifo_rxdata;
        repeat (3) cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("empty_read_hold", 32'(cmdfifo_rxdata), 32'(held));
        chk("empty_read_rxe", 32'(cmdfifo_rxe), 32'd1);

        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom), 8'($urandom), ($urandom % 4) != 0);
            if (i > 200) cmdfifo_rd = ($urandom % 4) == 0;
            rst_out_ack = 1'($urandom);
            tb_led      = ($urandom % 8) != 0;
        end
        tb_led = 1'b1;
        drain();
        rst_out_ack = 1'b0;

`ifdef LX9_LED_GATE_EN
        @(negedge tb_clk);
        tb_led = 1'b0;
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b1, 8'h5a, 1'b0);
        cyc(1'b1, 8'h5b, 1'b0);
        cyc(1'b1, 8'h5c, 1'b0);
        repeat (4) cyc(1'b0, 8'h00, 1'b0);
        chk("gate_rxe_held", 32'(cmdfifo_rxe), 32'd1);
        tb_led = 1'b1;
        n = 0;
        while (cmdfifo_rxe && n < 10) begin
            @(negedge tb_clk);
            n++;
        end
        chk("gate_resume", 32'(n <= 2), 32'd1);
        for (int i = 0; i < 3; i++) begin
            wait_rx("gate_wait");
            rd_byte(v);
            chk("gate_order", 32'(v), 32'(8'h5a + i));
        end
`endif

        cyc(1'b0, 8'h00, 1'b0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("rst_final_low", 32'(rst_out), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
